// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the FSM state enum, bit-period helper and MMIO constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    localparam int UART_DATA_BITS = 8;
    localparam logic [15:0] UART_ADDR_BASE = 16'h8300;
    localparam int TX_BUSY = 0;
    localparam int RX_PEND = 1;

    // Clocks per bit, rounded to nearest.
    function automatic int uart_bit_cycles(
        input int clk,
        input int baud
    );
        return (clk + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_deser_if.sv
// Received-byte handshake bundle (o_data/o_valid/i_ready).
// master: receiver drives data+valid; slave: consumer drives ready.
interface uart_rx_deser_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] o_data;
    logic                      o_valid;
    logic                      i_ready;

    modport master (
        output o_data,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        output i_ready
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: held at zero while i_run=0, then pulses o_tick
// after HALF cycles for the first tick and every BIT_CYCLES after.
module uart_bit_timer #(
    parameter int BIT_CYCLES = 50,
    parameter int HALF       = 25
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    output logic o_tick
);
    localparam int CW = $clog2(BIT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          first_q, first_d;

    always_comb begin
        cnt_d   = cnt_q;
        first_d = first_q;
        o_tick  = 1'b0;
        if (!i_run) begin
            cnt_d   = '0;
            first_d = 1'b1;
        end else if ((first_q && cnt_q == CW'(HALF - 1)) ||
                     (!first_q && cnt_q == CW'(BIT_CYCLES - 1))) begin
            o_tick  = 1'b1;
            cnt_d   = '0;
            first_d = 1'b0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            first_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive front end: sync, start detect, mid-bit sampling,
// valid/ready output and sticky frame/overrun flags.
// Ports: i_clk, i_rst_n, i_rx, rx_if (data/valid/ready), o_frame_err,
// o_overrun, [o_parity_err], i_clr_err, o_busy.
// Optional: define UART_RX_PARITY_EN for 8E1 with o_parity_err.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 2_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    uart_rx_deser_if.master rx_if,
    output logic o_frame_err,
    output logic o_overrun,
`ifdef UART_RX_PARITY_EN
    output logic o_parity_err,
`endif
    input  logic i_clr_err,
    output logic o_busy
);
    localparam int BIT_CYCLES = uart_bit_cycles(CLK_FREQ, BAUD_RATE);
    localparam int HALF       = BIT_CYCLES / 2;

    uart_state_e state_q, state_d;
    logic [1:0]  sync_q;
    logic        rx_s;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        tick, run, complete, ferr_set;
`ifdef UART_RX_PARITY_EN
    logic        perr_q, perr_d;
    logic        pbad_q, pbad_d;
    logic        perr_set;
`endif

    assign rx_s = sync_q[1];
    assign run  = state_q inside {START, DATA, PARITY, STOP};

    uart_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES),
        .HALF       (HALF)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_run   (run),
        .o_tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        complete = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_d   = pbad_q;
        perr_set = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef UART_RX_PARITY_EN
                pbad_d = 1'b0;
`endif
                if (!rx_s) state_d = START;
            end
            START: begin
                if (tick) begin
                    bit_d   = 3'd0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d[bit_q] = rx_s;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    // Even parity: data plus parity bit XOR to zero.
                    if (^{shift_q, rx_s}) begin
                        pbad_d   = 1'b1;
                        perr_set = 1'b1;
                    end
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        complete = !pbad_q;
`else
                        complete = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output handshake and sticky flags; a set beats a clear.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = i_clr_err ? 1'b0 : ovr_q;
        ferr_d  = (i_clr_err ? 1'b0 : ferr_q) | ferr_set;
`ifdef UART_RX_PARITY_EN
        perr_d  = (i_clr_err ? 1'b0 : perr_q) | perr_set;
`endif
        if (valid_q && rx_if.i_ready) valid_d = 1'b0;
        if (complete) begin
            if (!valid_q || rx_if.i_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], i_rx};
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            perr_q <= 1'b0;
            pbad_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
            pbad_q <= pbad_d;
        end
    end

    assign o_parity_err = perr_q;
`endif

    assign rx_if.o_data  = data_q;
    assign rx_if.o_valid = valid_q;
    assign o_frame_err   = ferr_q;
    assign o_overrun     = ovr_q;
    assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed self-checking bench for uart_rx_deser at 100 MHz / 2 Mbaud.
// Table of single frames plus hand-written multi-cycle sequences.
module tb_uart_rx_deser;

    localparam int BC = 50;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 478 + BC;
`else
    localparam int LAT = 478;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    logic clr_err;
    logic frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
    logic parity_err;
`endif

    int checks = 0;
    int errors = 0;

    uart_rx_deser_if rx_if ();

    uart_rx_deser dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx        (rx),
        .rx_if       (rx_if),
        .o_frame_err (frame_err),
        .o_overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(parity_err),
`endif
        .i_clr_err   (clr_err),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d,
                              input logic par,
                              input logic stop);
        rx = 1'b0;
        step(BC);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            step(BC);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        step(BC);
`else
        if (par) rx = 1'b1;
`endif
        rx = stop;
        step(BC);
    endtask

    task automatic accept();
        rx_if.i_ready = 1'b1;
        step(1);
        rx_if.i_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h5A, 8'h5A, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h81, 8'h81, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 8'h3C, 1'b0, 1'b0};

        rst_n = 1'b0;
        rx = 1'b1;
        clr_err = 1'b0;
        rx_if.i_ready = 1'b0;
        step(3);
        chk("rst_valid", {7'd0, rx_if.o_valid}, 8'd0);
        chk("rst_data", rx_if.o_data, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_ferr", {7'd0, frame_err}, 8'd0);
        chk("rst_ovr", {7'd0, overrun}, 8'd0);
        rst_n = 1'b1;
        step(5);

        // Exact completion latency from the i_rx start edge.
        fork
            send_frame(8'h5A, 1'b0, 1'b1);
            begin
                step(LAT - 1);
                chk("lat_before", {7'd0, rx_if.o_valid}, 8'd0);
                step(1);
                chk("lat_at", {7'd0, rx_if.o_valid}, 8'd1);
            end
        join
        accept();
        chk("lat_acc", {7'd0, rx_if.o_valid}, 8'd0);
        step(5);

        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].din, ^vecs[i].din, 1'b1);
            chk($sformatf("v%0d_valid", i),
                {7'd0, rx_if.o_valid}, 8'd1);
            chk($sformatf("v%0d_data", i),
                rx_if.o_data, vecs[i].exp_data);
            chk($sformatf("v%0d_ferr", i),
                {7'd0, frame_err}, {7'd0, vecs[i].exp_ferr});
            chk($sformatf("v%0d_ovr", i),
                {7'd0, overrun}, {7'd0, vecs[i].exp_ovr});
            accept();
            chk($sformatf("v%0d_acc", i),
                {7'd0, rx_if.o_valid}, 8'd0);
            step(3);
        end

        // Short glitch: false start.
        rx = 1'b0;
        step(5);
        chk("gl_busy", {7'd0, busy}, 8'd1);
        step(5);
        rx = 1'b1;
        step(40);
        chk("gl_idle", {7'd0, busy}, 8'd0);
        chk("gl_valid", {7'd0, rx_if.o_valid}, 8'd0);
        chk("gl_ferr", {7'd0, frame_err}, 8'd0);
        chk("gl_ovr", {7'd0, overrun}, 8'd0);

        // Framing error with line held low.
        send_frame(8'h00, 1'b0, 1'b0);
        step(3 * BC);
        chk("fe_ferr", {7'd0, frame_err}, 8'd1);
        chk("fe_valid", {7'd0, rx_if.o_valid}, 8'd0);
        chk("fe_busy", {7'd0, busy}, 8'd1);
        rx = 1'b1;
        step(5);
        chk("fe_idle", {7'd0, busy}, 8'd0);
        step(BC);
        send_frame(8'hA5, 1'b0, 1'b1);
        chk("fe_nx_valid", {7'd0, rx_if.o_valid}, 8'd1);
        chk("fe_nx_data", rx_if.o_data, 8'hA5);
        accept();
        pulse_clr();
        chk("fe_clr", {7'd0, frame_err}, 8'd0);

        // Overrun: second byte dropped.
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        chk("ov_data", rx_if.o_data, 8'h11);
        chk("ov_flag", {7'd0, overrun}, 8'd1);
        chk("ov_valid", {7'd0, rx_if.o_valid}, 8'd1);
        pulse_clr();
        chk("ov_clr", {7'd0, overrun}, 8'd0);
        accept();

        // Accept on the same cycle the next byte completes.
        send_frame(8'h11, 1'b0, 1'b1);
        fork
            send_frame(8'h22, 1'b0, 1'b1);
            begin
                step(LAT - 1);
                chk("sc_pre", {7'd0, rx_if.o_valid}, 8'd1);
                rx_if.i_ready = 1'b1;
                step(1);
                rx_if.i_ready = 1'b0;
                chk("sc_valid", {7'd0, rx_if.o_valid}, 8'd1);
                chk("sc_data", rx_if.o_data, 8'h22);
                chk("sc_ovr", {7'd0, overrun}, 8'd0);
            end
        join

        // Reset mid-frame with an unconsumed byte present.
        chk("mr_pre", {7'd0, rx_if.o_valid}, 8'd1);
        fork
            send_frame(8'h3C, 1'b0, 1'b1);
            begin
                step(200);
                rst_n = 1'b0;
                #1;
                chk("mr_valid", {7'd0, rx_if.o_valid}, 8'd0);
                chk("mr_data", rx_if.o_data, 8'd0);
                chk("mr_busy", {7'd0, busy}, 8'd0);
            end
        join
        step(2);
        rst_n = 1'b1;
        step(5);
        send_frame(8'hC3, 1'b0, 1'b1);
        chk("mr_nx_data", rx_if.o_data, 8'hC3);
        chk("mr_nx_valid", {7'd0, rx_if.o_valid}, 8'd1);
        chk("mr_nx_ferr", {7'd0, frame_err}, 8'd0);
        chk("mr_nx_ovr", {7'd0, overrun}, 8'd0);
        accept();
        step(5);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b0, 1'b1);
        chk("pe_ok_valid", {7'd0, rx_if.o_valid}, 8'd1);
        chk("pe_ok_data", rx_if.o_data, 8'h03);
        chk("pe_ok_err", {7'd0, parity_err}, 8'd0);
        accept();
        send_frame(8'h03, 1'b1, 1'b1);
        chk("pe_bad_err", {7'd0, parity_err}, 8'd1);
        chk("pe_bad_valid", {7'd0, rx_if.o_valid}, 8'd0);
        pulse_clr();
        chk("pe_clr", {7'd0, parity_err}, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
